// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with pixel-clock
// divider, sync polarity, pause (en) and synchronous restart.
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   en               1 = run, 0 = freeze divider, counters and outputs
//   restart          restart raster at pixel (0,0) on next clk
//   p_tick           1 clk pulse per pixel advance (combinational)
//   hsync, vsync     sync outputs, active level per HS_POL / VS_POL
//   video_on         inside visible area
//   x, y             current pixel coordinates
//   line_start       1 clk pulse on first clk of x==0
//   frame_start      1 clk pulse on first clk of x==0, y==0
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned CLK_DIV  = 2,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned CNT_W    = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             restart,
   output logic             p_tick,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             line_start,
   output logic             frame_start
);

   localparam int unsigned H_TOTAL =
      H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL =
      V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W =
      (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST =
      DIV_W'(CLK_DIV - 1);

   localparam logic [CNT_W-1:0] H_LAST =
      CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST =
      CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT =
      CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT =
      CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SB =
      CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SE =
      CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] V_SB =
      CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SE =
      CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;
   // fresh: counters just moved to a new pixel whose strobe is not yet shown
   logic             fresh_q, fresh_d;
   // pend: restart seen last clk, outputs must follow counters even if en=0
   logic             pend_q, pend_d;

   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             vid_q, vid_d;
   logic             ls_q, ls_d;
   logic             fs_q, fs_d;
   logic             upd;

   assign p_tick = en && (div_q == DIV_LAST);

   always_comb begin
      div_d   = div_q;
      h_d     = h_q;
      v_d     = v_q;
      fresh_d = fresh_q;
      pend_d  = restart;
      if (restart) begin
         div_d   = '0;
         h_d     = '0;
         v_d     = '0;
         fresh_d = 1'b1;
      end else if (en) begin
         fresh_d = p_tick;
         if (p_tick) begin
            div_d = '0;
            if (h_q == H_LAST) begin
               h_d = '0;
               if (v_q == V_LAST) begin
                  v_d = '0;
               end else begin
                  v_d = v_q + 1'b1;
               end
            end else begin
               h_d = h_q + 1'b1;
            end
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_comb begin
      upd  = en || pend_q;
      x_d  = x_q;
      y_d  = y_q;
      hs_d = hs_q;
      vs_d = vs_q;
      vid_d = vid_q;
      ls_d = 1'b0;
      fs_d = 1'b0;
      if (upd) begin
         x_d   = h_q;
         y_d   = v_q;
         vid_d = (h_q < H_ACT) && (v_q < V_ACT);
         hs_d  = ((h_q >= H_SB) && (h_q <= H_SE))
               ? HS_POL : ~HS_POL;
         vs_d  = ((v_q >= V_SB) && (v_q <= V_SE))
               ? VS_POL : ~VS_POL;
         ls_d  = en && fresh_q && (h_q == '0);
         fs_d  = ls_d && (v_q == '0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         fresh_q <= 1'b1;
         pend_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         vid_q   <= 1'b0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         div_q   <= div_d;
         h_q     <= h_d;
         v_q     <= v_d;
         fresh_q <= fresh_d;
         pend_q  <= pend_d;
         x_q     <= x_d;
         y_q     <= y_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         vid_q   <= vid_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign video_on    = vid_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-mode, 800x600 and small-mode instances;
// directed timing checks plus a randomized scoreboard on the small mode.
module tb_vga_timing_gen;

   localparam int C_HA = 12, C_HF = 2, C_HS = 3, C_HB = 3;
   localparam int C_VA = 5, C_VF = 1, C_VS = 2, C_VB = 2;
   localparam int C_HT = C_HA + C_HF + C_HS + C_HB;
   localparam int C_VT = C_VA + C_VF + C_VS + C_VB;
   localparam int C_D = 3;
   localparam bit C_HP = 1'b1, C_VP = 1'b0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   logic en_a, rs_a, en_b, rs_b, en_c, rs_c;
   logic pt_a, hs_a, vs_a, vo_a, ls_a, fs_a;
   logic pt_b, hs_b, vs_b, vo_b, ls_b, fs_b;
   logic pt_c, hs_c, vs_c, vo_c, ls_c, fs_c;
   logic [9:0] x_a, y_a;
   logic [10:0] x_b, y_b;
   logic [4:0] x_c, y_c;

   vga_timing_gen u_a (
      .clk(clk), .reset_n(reset_n), .en(en_a), .restart(rs_a),
      .p_tick(pt_a), .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
      .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
      .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
      .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11)
   ) u_b (
      .clk(clk), .reset_n(reset_n), .en(en_b), .restart(rs_b),
      .p_tick(pt_b), .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
      .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(C_HA), .H_FP(C_HF), .H_SYNC(C_HS), .H_BP(C_HB),
      .V_ACTIVE(C_VA), .V_FP(C_VF), .V_SYNC(C_VS), .V_BP(C_VB),
      .CLK_DIV(C_D), .HS_POL(C_HP), .VS_POL(C_VP), .CNT_W(5)
   ) u_c (
      .clk(clk), .reset_n(reset_n), .en(en_c), .restart(rs_c),
      .p_tick(pt_c), .hsync(hs_c), .vsync(vs_c), .video_on(vo_c),
      .x(x_c), .y(y_c), .line_start(ls_c), .frame_start(fs_c)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string nm, input longint act,
                        input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic [4:0] x;
      logic [4:0] y;
      logic       vid;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
   } cexp_t;

   cexp_t sbq[$];
   bit c_go = 1'b0;
   bit c_done = 1'b0;

   // expected visible state of linear pixel index p in the small mode
   function automatic cexp_t c_view(input int p);
      cexp_t r;
      int xx = p % C_HT;
      int yy = p / C_HT;
      r.x = 5'(xx);
      r.y = 5'(yy);
      r.vid = (xx < C_HA) && (yy < C_VA);
      r.hs = (xx >= C_HA + C_HF && xx < C_HA + C_HF + C_HS)
           ? C_HP : !C_HP;
      r.vs = (yy >= C_VA + C_VF && yy < C_VA + C_VF + C_VS)
           ? C_VP : !C_VP;
      r.ls = 1'b0;
      r.fs = 1'b0;
      return r;
   endfunction

   // small-mode driver and reference model
   initial begin
      int m_p, m_ph;
      bit m_fresh, m_pend, upd;
      cexp_t m_o, e;
      en_c = 1'b0;
      rs_c = 1'b0;
      wait (c_go);
      m_p = 0;
      m_ph = 0;
      m_fresh = 1'b1;
      m_pend = 1'b0;
      m_o = '0;
      m_o.hs = !C_HP;
      m_o.vs = !C_VP;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (((i / 300) % 2) == 1)
            en_c = ($urandom_range(0, 1) != 0);
         else
            en_c = ($urandom_range(0, 9) != 0);
         rs_c = ($urandom_range(0, 60) == 0);
         #1;
         check("c_p_tick", pt_c, en_c && (m_ph == C_D - 1));
         upd = en_c || m_pend;
         e = m_o;
         e.ls = 1'b0;
         e.fs = 1'b0;
         if (upd) begin
            e = c_view(m_p);
            e.ls = en_c && m_fresh && (e.x == 0);
            e.fs = e.ls && (e.y == 0);
         end
         sbq.push_back(e);
         m_o = e;
         if (rs_c) begin
            m_p = 0;
            m_ph = 0;
            m_fresh = 1'b1;
         end else if (en_c) begin
            if (m_ph == C_D - 1) begin
               m_ph = 0;
               m_p = (m_p + 1) % (C_HT * C_VT);
               m_fresh = 1'b1;
            end else begin
               m_ph++;
               m_fresh = 1'b0;
            end
         end
         m_pend = rs_c;
      end
      @(negedge clk);
      en_c = 1'b0;
      rs_c = 1'b0;
      c_done = 1'b1;
   end

   // small-mode monitor
   initial forever begin
      @(posedge clk);
      #1;
      if (sbq.size() != 0) begin
         cexp_t e;
         e = sbq.pop_front();
         check("c_outputs",
               {x_c, y_c, vo_c, hs_c, vs_c, ls_c, fs_c}, e);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int a_last, b_last, a_vid, a_hlo, b_hhi;
      int a_lines, b_lines, b_pt0, a_fs, bad, n;
      bit a_hsp, b_hsp, found;
      logic [9:0] hx, hy, px;
      logic hh;

      reset_n = 1'b0;
      en_a = 1'b1; rs_a = 1'b0;
      en_b = 1'b1; rs_b = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (1000) @(negedge clk);

      // asynchronous reset mid-frame
      #3 reset_n = 1'b0;
      #1;
      check("rst_x", x_a, 0);
      check("rst_y", y_a, 0);
      check("rst_video_on", vo_a, 0);
      check("rst_hsync", hs_a, 1);
      check("rst_vsync", vs_a, 1);
      check("rst_strobes", {ls_a, fs_a}, 0);
      check("rst_p_tick", pt_a, 0);
      check("rst_b_sync", {hs_b, vs_b}, 0);
      check("rst_b_x", x_b, 0);
      @(negedge clk);
      reset_n = 1'b1;
      c_go = 1'b1;
      @(posedge clk);
      #1;
      check("rel_frame_start", fs_a, 1);
      check("rel_line_start", ls_a, 1);
      check("rel_b_frame_start", fs_b, 1);
      check("rel_xy", {x_a, y_a}, 0);

      // free-run line timing on default and 800x600 modes
      a_last = 0; b_last = 0;
      a_vid = int'(vo_a); a_hlo = int'(!hs_a); a_hsp = hs_a;
      b_hhi = int'(hs_b); b_hsp = hs_b;
      a_lines = 0; b_lines = 0; b_pt0 = 0; a_fs = 0;
      for (int i = 1; i <= 5000; i++) begin
         @(posedge clk);
         #1;
         if (!pt_b) b_pt0++;
         if (fs_a) a_fs++;
         if (ls_a) begin
            check("a_line_period", i - a_last, 1600);
            check("a_video_on_clks", a_vid, 1280);
            check("a_hsync_low_clks", a_hlo, 192);
            check("a_ls_x", x_a, 0);
            a_last = i; a_vid = 0; a_hlo = 0; a_lines++;
         end
         a_vid += int'(vo_a);
         a_hlo += int'(!hs_a);
         if (a_hsp && !hs_a) check("a_hsync_on_x", x_a, 656);
         if (!a_hsp && hs_a) check("a_hsync_off_x", x_a, 752);
         a_hsp = hs_a;
         if (ls_b) begin
            check("b_line_period", i - b_last, 1056);
            check("b_hsync_high_clks", b_hhi, 128);
            b_last = i; b_hhi = 0; b_lines++;
         end
         b_hhi += int'(hs_b);
         if (!b_hsp && hs_b) check("b_hsync_on_x", x_b, 840);
         if (b_hsp && !hs_b) check("b_hsync_off_x", x_b, 968);
         b_hsp = hs_b;
      end
      check("a_lines", a_lines, 3);
      check("b_lines", b_lines, 4);
      check("b_p_tick_gaps", b_pt0, 0);
      check("a_no_frame_start", a_fs, 0);

      // pause at x=100
      found = 1'b0;
      px = x_a;
      for (int k = 0; k < 4000 && !found; k++) begin
         @(posedge clk);
         #1;
         if (x_a == 10'd100 && px == 10'd99) found = 1'b1;
         px = x_a;
      end
      check("a_find_x100", found, 1);
      @(negedge clk);
      en_a = 1'b0;
      hx = x_a; hy = y_a; hh = hs_a;
      bad = 0;
      repeat (37) begin
         #1;
         if (pt_a) bad++;
         @(posedge clk);
         #1;
         if (x_a != hx || y_a != hy || hs_a != hh || ls_a) bad++;
         @(negedge clk);
      end
      check("a_freeze_holds", bad, 0);
      check("a_freeze_x", x_a, 100);
      en_a = 1'b1;
      n = 0;
      while (x_a != 10'd101 && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("a_resume_clks", n, 2);

      // restart at x=400 with en=1
      found = 1'b0;
      for (int k = 0; k < 4000 && !found; k++) begin
         @(posedge clk);
         #1;
         if (x_a == 10'd400) found = 1'b1;
      end
      check("a_find_x400", found, 1);
      @(negedge clk);
      rs_a = 1'b1;
      @(posedge clk);
      #1;
      check("rs_fs_early", fs_a, 0);
      @(negedge clk);
      rs_a = 1'b0;
      @(posedge clk);
      #1;
      check("rs_xy", {x_a, y_a}, 0);
      check("rs_strobes", {ls_a, fs_a}, 2'b11);

      // restart with en=0
      found = 1'b0;
      for (int k = 0; k < 4000 && !found; k++) begin
         @(posedge clk);
         #1;
         if (x_a == 10'd400) found = 1'b1;
      end
      check("a_find_x400_b", found, 1);
      @(negedge clk);
      en_a = 1'b0;
      rs_a = 1'b1;
      @(negedge clk);
      rs_a = 1'b0;
      @(posedge clk);
      #1;
      check("rs_en0_xy", {x_a, y_a}, 0);
      check("rs_en0_strobes", {ls_a, fs_a}, 0);
      @(negedge clk);
      en_a = 1'b1;

      for (int k = 0; k < 20000 && !c_done; k++) @(negedge clk);
      check("c_done", c_done, 1);
      repeat (3) @(posedge clk);
      #2;
      check("c_queue_empty", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
